// File: rtl/scan_dec_pkg.sv
// Shared types and constants for the scanning one-cold decoder.
//   state_e     : FSM states (OFF, BLANK, DRIVE)
//   MODE_DIRECT : MODE input value selecting address-load operation
//   MODE_SCAN   : MODE input value selecting auto-stepping operation
package scan_dec_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onecold_dec.sv
// Combinational SEL_W-to-2**SEL_W decoder with active-low, one-cold output.
//   sel      : channel index
//   en       : 1 = drive the selected bit low, 0 = all outputs high
//   oc_n_c   : active-low one-cold vector (combinational)
module onecold_dec #(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [2**SEL_W-1:0]   oc_n_c
);

  localparam int unsigned N_OUT = 2 ** SEL_W;

  always_comb begin
    oc_n_c = '1;
    if (en) begin
      oc_n_c = ~(N_OUT'(1) << sel);
    end
  end

endmodule

// File: rtl/scan_onecold_decoder.sv
// Registered one-cold channel decoder with DIRECT (address load) and SCAN
// (auto-step with programmable dwell) modes. Every channel change passes
// through a single all-high BLANK cycle (break-before-make).
//   CLK, RST : clock, synchronous active-high reset
//   EN       : 0 forces all outputs high and parks the FSM in OFF
//   MODE     : 0 = DIRECT, 1 = SCAN
//   LOAD, A  : DIRECT-mode address capture
//   LAST     : SCAN upper channel bound (channels 0..LAST)
//   DWELL    : SCAN drive time per channel, DWELL+1 cycles
//   Y        : active-low one-cold outputs
//   CUR      : current channel
//   WRAP     : one-cycle pulse in the BLANK cycle of a LAST->0 wrap
//   ACTIVE   : high while a Y bit is driven low
module scan_onecold_decoder
  import scan_dec_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 MODE,
  input  logic                 LOAD,
  input  logic [SEL_W-1:0]     A,
  input  logic [SEL_W-1:0]     LAST,
  input  logic [DWELL_W-1:0]   DWELL,
  output logic [2**SEL_W-1:0]  Y,
  output logic [SEL_W-1:0]     CUR,
  output logic                 WRAP,
  output logic                 ACTIVE
);

  localparam int unsigned N_OUT = 2 ** SEL_W;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               wrap_q, wrap_d;
  logic               active_q, active_d;
  logic [N_OUT-1:0]   y_q, y_d;
  logic [SEL_W-1:0]   next_chan_c;
  logic [N_OUT-1:0]   dec_y_c;

  // Next scan channel; ">=" also catches LAST lowered below CUR mid-scan.
  always_comb begin
    next_chan_c = SEL_W'(cur_q + SEL_W'(1));
    if (cur_q >= LAST) begin
      next_chan_c = '0;
    end
  end

  // FSM next-state, channel and dwell counter.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    mode_d  = MODE;

    if (!EN) begin
      state_d = OFF;
      dwell_d = '0;
    end else if (MODE == MODE_SCAN) begin
      if (mode_q == MODE_DIRECT) begin
        // Entering SCAN restarts at channel 0 without a WRAP pulse.
        state_d = BLANK;
        cur_d   = '0;
        dwell_d = '0;
      end else begin
        unique case (state_q)
          OFF: begin
            state_d = BLANK;
            dwell_d = '0;
          end
          BLANK: begin
            state_d = DRIVE;
            dwell_d = '0;
          end
          DRIVE: begin
            if (dwell_q == DWELL) begin
              state_d = BLANK;
              cur_d   = next_chan_c;
              dwell_d = '0;
              wrap_d  = (next_chan_c == '0);
            end else begin
              dwell_d = DWELL_W'(dwell_q + DWELL_W'(1));
            end
          end
          default: begin
            state_d = OFF;
            dwell_d = '0;
          end
        endcase
      end
    end else begin
      dwell_d = '0;
      if (LOAD && ((state_q != DRIVE) || (A != cur_q))) begin
        state_d = BLANK;
        cur_d   = A;
      end else if (state_q == OFF) begin
        state_d = BLANK;
      end else if (state_q == BLANK) begin
        state_d = DRIVE;
      end
    end
  end

  // Output pattern is decoded from the next state so Y, CUR and ACTIVE align.
  onecold_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (cur_d),
    .en     (state_d == DRIVE),
    .oc_n_c (dec_y_c)
  );

  always_comb begin
    y_d      = dec_y_c;
    active_d = (state_d == DRIVE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= OFF;
      cur_q    <= '0;
      dwell_q  <= '0;
      mode_q   <= MODE_DIRECT;
      wrap_q   <= 1'b0;
      active_q <= 1'b0;
      y_q      <= '1;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      dwell_q  <= dwell_d;
      mode_q   <= mode_d;
      wrap_q   <= wrap_d;
      active_q <= active_d;
      y_q      <= y_d;
    end
  end

  assign Y      = y_q;
  assign CUR    = cur_q;
  assign WRAP   = wrap_q;
  assign ACTIVE = active_q;

endmodule

// File: tb/tb_scan_onecold_decoder.sv
// Self-checking bench for scan_onecold_decoder: directed scenarios plus a
// randomized run, all checked against a cycle-level behavioural model.
module tb_scan_onecold_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       load;
  logic [2:0] a;
  logic [2:0] last;
  logic [7:0] dwell;
  logic [7:0] y;
  logic [2:0] cur;
  logic       wrap;
  logic       active;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: phase 0 = off, 1 = blank, 2 = drive
  int m_phase = 0;
  int m_cur   = 0;
  int m_dw    = 0;
  int m_wrap  = 0;
  int m_mprev = 0;

  scan_onecold_decoder dut (
    .CLK    (clk),
    .RST    (rst),
    .EN     (en),
    .MODE   (mode),
    .LOAD   (load),
    .A      (a),
    .LAST   (last),
    .DWELL  (dwell),
    .Y      (y),
    .CUR    (cur),
    .WRAP   (wrap),
    .ACTIVE (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock of the reference behaviour, using the inputs seen at the edge.
  task automatic model_step();
    int nxt;
    if (rst) begin
      m_phase = 0; m_cur = 0; m_dw = 0; m_wrap = 0; m_mprev = 0;
      return;
    end
    m_wrap = 0;
    if (!en) begin
      m_phase = 0;
      m_dw    = 0;
    end else if (mode) begin
      if (m_mprev == 0) begin
        m_cur = 0; m_dw = 0; m_phase = 1;
      end else if (m_phase == 2) begin
        if (m_dw == int'(dwell)) begin
          nxt     = (m_cur >= int'(last)) ? 0 : m_cur + 1;
          m_wrap  = (nxt == 0) ? 1 : 0;
          m_cur   = nxt;
          m_dw    = 0;
          m_phase = 1;
        end else begin
          m_dw = (m_dw + 1) % 256;
        end
      end else begin
        m_phase = m_phase + 1;
        m_dw    = 0;
      end
    end else begin
      m_dw = 0;
      if (load && (m_phase != 2 || int'(a) != m_cur)) begin
        m_cur = int'(a); m_phase = 1;
      end else if (m_phase != 2) begin
        m_phase = m_phase + 1;
      end
    end
    m_mprev = mode ? 1 : 0;
  endtask

  function automatic logic [7:0] exp_y();
    if (m_phase == 2) return 8'(255 - (1 << m_cur));
    return 8'hFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("y",      32'(y),      32'(exp_y()));
    check("cur",    32'(cur),    32'(m_cur));
    check("wrap",   32'(wrap),   32'(m_wrap));
    check("active", 32'(active), (m_phase == 2) ? 32'd1 : 32'd0);
  endtask

  logic [7:0] seq_y [11] = '{8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD,
                             8'hFF, 8'hFB, 8'hFB, 8'hFF, 8'hFE};

  initial begin
    logic [2:0] prev_cur;
    bit         found;

    rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b1; a = 3'd0;
    last = 3'd7; dwell = 8'd0;

    // Reset holds everything inactive regardless of LOAD/EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_y", 32'(y), 32'hFF);
      check("rst_cur", 32'(cur), 32'd0);
      check("rst_active", 32'(active), 32'd0);
    end
    rst = 1'b0; load = 1'b0;
    tick(); check("rel_blank", 32'(y), 32'hFF);
    tick(); check("rel_drive", 32'(y), 32'hFE);

    // DIRECT load and redundant reload
    load = 1'b1; a = 3'd5;
    tick(); load = 1'b0;
    check("ld_blank_y", 32'(y), 32'hFF);
    check("ld_blank_cur", 32'(cur), 32'd5);
    tick();
    check("ld_drive_y", 32'(y), 32'hDF);
    check("ld_drive_act", 32'(active), 32'd1);
    load = 1'b1;
    tick(); load = 1'b0;
    check("reload_noblank", 32'(y), 32'hDF);

    // SCAN sequence LAST=2, DWELL=1
    last = 3'd2; dwell = 8'd1; mode = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      check($sformatf("scan_seq%0d", i), 32'(y), 32'(seq_y[i]));
      check($sformatf("scan_wrap%0d", i), 32'(wrap), (i == 9) ? 32'd1 : 32'd0);
    end

    // Lowering LAST below CUR forces a wrap on the next advance
    last = 3'd6; dwell = 8'd3;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (cur == 3'd4 && active) found = 1'b1;
    end
    check("lastlow_reach", 32'(found), 32'd1);
    last = 3'd1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (cur != 3'd4) found = 1'b1;
    end
    check("lastlow_adv", 32'(found), 32'd1);
    check("lastlow_cur", 32'(cur), 32'd0);
    check("lastlow_wrap", 32'(wrap), 32'd1);

    // EN=0 overrides LOAD; re-enable blanks once then drives held channel
    mode = 1'b0; load = 1'b1; a = 3'd3;
    tick(); load = 1'b0;
    tick();
    check("en_pre_y", 32'(y), 32'hF7);
    en = 1'b0; load = 1'b1; a = 3'd6;
    tick();
    check("en_off_y", 32'(y), 32'hFF);
    check("en_off_cur", 32'(cur), 32'd3);
    en = 1'b1; load = 1'b0;
    tick(); check("en_blank_y", 32'(y), 32'hFF);
    tick(); check("en_drive_y", 32'(y), 32'hF7);

    // Randomized run with invariant checks
    for (int i = 0; i < 10000; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      load = ($urandom_range(0, 4) == 0);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) last = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) dwell = 8'($urandom_range(0, 5));
      prev_cur = cur;
      tick();
      check("onecold", ($countones(~y) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (cur != prev_cur) check("bbm_blank", 32'(y), 32'hFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
